alu_status_unit: RTL
====================

ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 20, program-counter/address width.
REQ-002 The module SHALL have parameter TRAP_VEC, default 20'h00000, trap entry address.
REQ-003 The module SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 The module SHALL have ports: alu_valid in 1, ALU flags valid; alu_zero, alu_sign, alu_carry in 1 each; alu_mode in 1, 1 = full-word, 0 = half-word.
REQ-005 The module SHALL have ports: op_valid in 1; op in 3, where 000=NOP, 001=LSR, 010=XSR, 011=JMP, 100=JZ, 101=JS, 110=JZS, 111=TRAP.
REQ-006 The module SHALL have ports: sr_din in 8, LSR/XSR operand; pc_in in ADDR_W; jump_target in ADDR_W; trap_ack in 1.
REQ-007 The module SHALL have outputs: sr out 8, status register; next_pc out ADDR_W; jump_taken out 1; trap out 1; op_done out 1.

Function
REQ-008 SR bit map SHALL be: [0] zero, [1] sign, [2] carry, [3] mode, [4] trap (read-only), [7:5] reserved and always 0.
REQ-009 FSM states SHALL be RUN, TRAP_ENTER and TRAP.
REQ-010 In RUN with alu_valid=1, SR[3:0] SHALL load {alu_mode, alu_carry, alu_sign, alu_zero} on the next edge.
REQ-011 LSR SHALL set SR[3:0] to sr_din[3:0]; XSR SHALL set SR[3:0] to SR[3:0] XOR sr_din[3:0]; SR[7:4] SHALL be unaffected.
REQ-012 If LSR or XSR coincides with alu_valid, the op SHALL win and the ALU flags SHALL be discarded.
REQ-013 Jump conditions SHALL use the registered SR before this edge: JMP always; JZ if SR[0]; JS if SR[1]; JZS if SR[0] OR SR[1].
REQ-014 An accepted op in RUN SHALL give, one cycle later, a one-cycle op_done pulse with jump_taken = condition and next_pc = jump_target if taken, else pc_in+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-015 NOP SHALL produce op_done with jump_taken=0 and next_pc=pc_in+1.
REQ-016 TRAP in RUN SHALL move to TRAP_ENTER; TRAP_ENTER SHALL set SR[4]=1, next_pc=TRAP_VEC, op_done=1 and move to TRAP after one cycle.
REQ-017 In TRAP_ENTER and TRAP, trap SHALL be 1 and op_valid and alu_valid SHALL be ignored, with no op_done.
REQ-018 trap_ack in TRAP SHALL return to RUN next edge and clear SR[4]; trap_ack in RUN or TRAP_ENTER SHALL be ignored.
REQ-019 jump_taken and op_done SHALL be low in every cycle without a completing op.

Reset
REQ-020 rst SHALL override all inputs at the edge, including mid-trap and coincident op_valid.
REQ-021 After reset: state RUN, sr=8'h00, next_pc=0, jump_taken=0, trap=0, op_done=0, and the shadow register (if present) =0.

Configuration
REQ-022 With macro SR_SAVE_EN defined, TRAP_ENTER SHALL copy SR[3:0] into an internal shadow and trap_ack SHALL restore SR[3:0] from it.
REQ-023 Without SR_SAVE_EN there SHALL be no shadow register, and SR[3:0] SHALL keep its value across trap entry and exit.

Verification
REQ-024 Reset, then alu_valid with zero=1, sign=0, carry=1, mode=1 -> next cycle sr=8'h0D.
REQ-025 sr=8'h01, JZ, pc_in=20'h00010, target=20'h00400 -> one cycle later op_done=1, jump_taken=1, next_pc=20'h00400; same with JS -> jump_taken=0, next_pc=20'h00011.
REQ-026 pc_in=20'hFFFFF, NOP -> next_pc=20'h00000, jump_taken=0.
REQ-027 XSR sr_din=8'hFF coincident with alu_valid, sr=8'h05 -> sr=8'h0A and the ALU flags are ignored.
REQ-028 With SR_SAVE_EN and sr=8'h03: TRAP -> trap=1, sr=8'h13, next_pc=TRAP_VEC; LSR 8'h00 during TRAP is ignored; trap_ack -> sr=8'h03, trap=0.
REQ-029 rst asserted in the TRAP state with op_valid=1 -> next cycle state RUN, all outputs 0.

Source files
------------

// File: rtl/alu_status_unit.sv
//------------------------------------------------------------------------------
// Module  : alu_status_unit
// Brief   : Status register, conditional jump resolution and trap sequencing.
//           Optional macro SR_SAVE_EN adds a shadow of SR[3:0] across traps.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_status_unit #(
    parameter int                 ADDR_W   = 20,
    parameter logic [ADDR_W-1:0]  TRAP_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    input  logic              alu_mode,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [7:0]        sr_din,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              trap_ack,
    output logic [7:0]        sr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              jump_taken,
    output logic              trap,
    output logic              op_done
);

    localparam logic [2:0] c_op_nop  = 3'b000;
    localparam logic [2:0] c_op_lsr  = 3'b001;
    localparam logic [2:0] c_op_xsr  = 3'b010;
    localparam logic [2:0] c_op_jmp  = 3'b011;
    localparam logic [2:0] c_op_jz   = 3'b100;
    localparam logic [2:0] c_op_js   = 3'b101;
    localparam logic [2:0] c_op_jzs  = 3'b110;
    localparam logic [2:0] c_op_trap = 3'b111;

    typedef enum logic [1:0] {
        S_RUN        = 2'b00,
        S_TRAP_ENTER = 2'b01,
        S_TRAP       = 2'b10
    } state_t;

    state_t            r_state, w_state_next;
    logic [3:0]        r_sr_lo, w_sr_lo_next;
    logic              r_sr_trap, w_sr_trap_next;
    logic [ADDR_W-1:0] r_next_pc, w_next_pc_next;
    logic              r_jump_taken, w_jump_next;
    logic              r_op_done, w_done_next;
    logic              w_cond;
    logic              w_unused;

    // Upper operand bits carry no meaning for LSR/XSR.
    assign w_unused = ^sr_din[7:4];

`ifdef SR_SAVE_EN
    logic [3:0] r_shadow, w_shadow_next;
`endif

    // Jump condition is judged on the SR value held before this edge.
    always_comb begin
        w_cond = 1'b0;
        case (op)
            c_op_jmp: w_cond = 1'b1;
            c_op_jz:  w_cond = r_sr_lo[0];
            c_op_js:  w_cond = r_sr_lo[1];
            c_op_jzs: w_cond = r_sr_lo[0] | r_sr_lo[1];
            default:  w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_sr_lo_next   = r_sr_lo;
        w_sr_trap_next = r_sr_trap;
        w_next_pc_next = r_next_pc;
        w_jump_next    = 1'b0;
        w_done_next    = 1'b0;
`ifdef SR_SAVE_EN
        w_shadow_next  = r_shadow;
`endif
        case (r_state)
            S_RUN: begin
                if (alu_valid) begin
                    w_sr_lo_next = {alu_mode, alu_carry, alu_sign, alu_zero};
                end
                if (op_valid) begin
                    if (op == c_op_trap) begin
                        w_state_next = S_TRAP_ENTER;
                    end else begin
                        // Explicit SR writes take priority over ALU flag updates.
                        if (op == c_op_lsr) begin
                            w_sr_lo_next = sr_din[3:0];
                        end else if (op == c_op_xsr) begin
                            w_sr_lo_next = r_sr_lo ^ sr_din[3:0];
                        end
                        w_done_next    = 1'b1;
                        w_jump_next    = w_cond;
                        w_next_pc_next = w_cond ? jump_target : pc_in + ADDR_W'(1);
                    end
                end
            end
            S_TRAP_ENTER: begin
                w_sr_trap_next = 1'b1;
                w_next_pc_next = TRAP_VEC;
                w_done_next    = 1'b1;
                w_state_next   = S_TRAP;
`ifdef SR_SAVE_EN
                w_shadow_next  = r_sr_lo;
`endif
            end
            S_TRAP: begin
                if (trap_ack) begin
                    w_sr_trap_next = 1'b0;
                    w_state_next   = S_RUN;
`ifdef SR_SAVE_EN
                    w_sr_lo_next   = r_shadow;
`endif
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_sr_lo      <= 4'h0;
            r_sr_trap    <= 1'b0;
            r_next_pc    <= '0;
            r_jump_taken <= 1'b0;
            r_op_done    <= 1'b0;
`ifdef SR_SAVE_EN
            r_shadow     <= 4'h0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_sr_lo      <= w_sr_lo_next;
            r_sr_trap    <= w_sr_trap_next;
            r_next_pc    <= w_next_pc_next;
            r_jump_taken <= w_jump_next;
            r_op_done    <= w_done_next;
`ifdef SR_SAVE_EN
            r_shadow     <= w_shadow_next;
`endif
        end
    end

    assign sr         = {3'b000, r_sr_trap, r_sr_lo};
    assign next_pc    = r_next_pc;
    assign jump_taken = r_jump_taken;
    assign op_done    = r_op_done;
    assign trap       = (r_state != S_RUN);

endmodule

`default_nettype wire
